// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between one master and one slave.
// All five channels: write address (AW), write data (W), write response (B),
// read address (AR) and read data (R).
// Modports:
//   master - drives addresses, write data, VALIDs on AW/W/AR, and BREADY/RREADY.
//   slave  - drives AWREADY/WREADY/ARREADY and the B and R response channels.
interface axi4_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AWADDR;
  logic                M_AWVALID;
  logic                M_AWREADY;
  logic [DATA_W-1:0]   M_WDATA;
  logic [DATA_W/8-1:0] M_WSTRB;
  logic                M_WVALID;
  logic                M_WREADY;
  logic [1:0]          M_BRESP;
  logic                M_BVALID;
  logic                M_BREADY;
  logic [ADDR_W-1:0]   M_ARADDR;
  logic                M_ARVALID;
  logic                M_ARREADY;
  logic [DATA_W-1:0]   M_RDATA;
  logic [1:0]          M_RRESP;
  logic                M_RVALID;
  logic                M_RREADY;

  modport master (
    output M_AWADDR, M_AWVALID, input M_AWREADY,
    output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
    input M_BRESP, M_BVALID, output M_BREADY,
    output M_ARADDR, M_ARVALID, input M_ARREADY,
    input M_RDATA, M_RRESP, M_RVALID, output M_RREADY
  );

  modport slave (
    input M_AWADDR, M_AWVALID, output M_AWREADY,
    input M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
    output M_BRESP, M_BVALID, input M_BREADY,
    input M_ARADDR, M_ARVALID, output M_ARREADY,
    output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master.
// Takes one read or write command from the local command port, runs it over
// the AXI4-Lite channels and returns read data plus response code on the
// local response port.
// Ports:
//   ACLK, ARESETn  - clock; synchronous reset, active-high despite the name
//   cmd_*          - command request (valid/ready, write, addr, wdata, wstrb)
//   rsp_*          - response (valid/ready, rdata, resp)
//   timeout_err    - sticky flag: a channel made no progress for TIMEOUT cycles
//   m              - AXI4-Lite bus, master side
module axi4_lite_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                timeout_err,
  axi4_lite_master_if.master  m
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, WRITE, WRESP, RD_ADDR, RD_DATA, DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;
  logic              awvalid_q;
  logic              wvalid_q;
  logic              bready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              rsp_valid_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, busy;

  assign aw_hs  = awvalid_q & m.M_AWREADY;
  assign w_hs   = wvalid_q  & m.M_WREADY;
  assign b_hs   = bready_q  & m.M_BVALID;
  assign ar_hs  = arvalid_q & m.M_ARREADY;
  assign r_hs   = rready_q  & m.M_RVALID;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign busy   = (state_q == WRITE) || (state_q == WRESP) ||
                  (state_q == RD_ADDR) || (state_q == RD_DATA);

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rdata_q       <= '0;
      resp_q        <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      // Progress watchdog: only counts while waiting on the bus and saturates
      // at TIMEOUT so the flag is raised exactly once per stall.
      if (!busy || any_hs) begin
        cnt_q <= '0;
      end else if (TIMEOUT != 0 && cnt_q != TO_MAX) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == TO_LAST) timeout_err_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            if (cmd_write) begin
              state_q   <= WRITE;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          // A channel counts as done if it completes now or already has.
          if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
            state_q  <= WRESP;
            bready_q <= 1'b1;
          end
        end
        WRESP: begin
          if (b_hs) begin
            resp_q      <= m.M_BRESP;
            rdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rdata_q     <= m.M_RDATA;
            resp_q      <= m.M_RRESP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign timeout_err = timeout_err_q;

  assign m.M_AWADDR  = addr_q;
  assign m.M_AWVALID = awvalid_q;
  assign m.M_WDATA   = wdata_q;
  assign m.M_WSTRB   = wstrb_q;
  assign m.M_WVALID  = wvalid_q;
  assign m.M_BREADY  = bready_q;
  assign m.M_ARADDR  = addr_q;
  assign m.M_ARVALID = arvalid_q;
  assign m.M_RREADY  = rready_q;

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
Single-outstanding AXI4-Lite master (initiator). It accepts one read or write command at a time from a local command port and drives the five AXI4-Lite channels toward a slave. It returns read data and the response code on a local response port. It sits between local control logic and any of the team's AXI4-Lite slave blocks.

Parameters:
ADDR_W, 32, address width of cmd_addr, M_AWADDR, M_ARADDR
DATA_W, 32, data width; WSTRB width is DATA_W/8
TIMEOUT, 256, cycles without channel progress before timeout_err sets; 0 disables

Ports:
ACLK  input  1  clock; all logic on rising edge
ARESETn  input  1  reset, synchronous, active-high (despite the name)
cmd_valid  input  1  command request
cmd_ready  output  1  master idle, command accepted when cmd_valid&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  transaction address
cmd_wdata  input  DATA_W  write data
cmd_wstrb  input  DATA_W/8  write byte strobes
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_resp  output  2  captured BRESP/RRESP
timeout_err  output  1  sticky timeout flag
M_AWADDR/M_AWVALID/M_AWREADY  out/out/in  ADDR_W/1/1  write address channel
M_WDATA/M_WSTRB/M_WVALID/M_WREADY  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel
M_BRESP/M_BVALID/M_BREADY  in/in/out  2/1/1  write response channel
M_ARADDR/M_ARVALID/M_ARREADY  out/out/in  ADDR_W/1/1  read address channel
M_RDATA/M_RRESP/M_RVALID/M_RREADY  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
- Reset (ARESETn=1 at edge): state=IDLE; all M_*VALID, M_BREADY, M_RREADY, rsp_valid, timeout_err=0; addr/data/strb/rdata/resp regs=0. Reset mid-transaction drops all valids the next cycle with no completion.
- cmd_ready = (state==IDLE). Only one transaction is outstanding.
- IDLE: on cmd_valid, latch addr/wdata/wstrb/write.
  - Write: go to WRITE; M_AWVALID=M_WVALID=1 next cycle.
  - Read: go to RD_ADDR; M_ARVALID=1 next cycle.
- WRITE: AW and W complete independently. Each VALID is held with stable payload until its READY is sampled high, then drops the following cycle. Once both have completed (same cycle or different cycles), go to WRESP with M_BREADY=1.
- WRESP: on M_BVALID&M_BREADY, capture M_BRESP, clear rdata, drop M_BREADY, go to DONE. M_BVALID seen before WRESP is ignored; the slave must hold it.
- RD_ADDR: hold M_ARVALID until M_ARREADY, then go to RD_DATA with M_RREADY=1.
- RD_DATA: on M_RVALID&M_RREADY, capture M_RDATA/M_RRESP, drop M_RREADY, go to DONE.
- DONE: rsp_valid=1, data stable until rsp_ready. Then go to IDLE; cmd_ready=1 next cycle.
- Latency with zero-wait slave (READY tied high, response VALID one cycle after address): command accepted at edge N → address VALID at N+1 → B/R handshake at N+2 → rsp_valid at N+3. Back-to-back throughput is one transaction per 4 cycles.
- Timeout: a counter runs in WRITE/WRESP/RD_ADDR/RD_DATA and clears on any channel handshake and on entry to IDLE. When it reaches TIMEOUT, timeout_err sets and holds until reset. The transaction is not aborted; the protocol stays legal.
- Response codes pass through unmodified; the master does not act on SLVERR/DECERR.
- ADDR_W/DATA_W registers have fixed width with no truncation; strobes are passed as given, including all-zero.

Test Plan:
- Zero-wait write: cmd addr=0x10, wdata=0xDEADBEEF, wstrb=0xF → AW/W VALID at N+1 with those values, BREADY at N+2, rsp_valid at N+3 with resp=00, rdata=0.
- Zero-wait read: slave returns RDATA=0xCAFEF00D, RRESP=00 → rsp_rdata=0xCAFEF00D, resp=00 at N+3; cmd_ready low N+1..N+3.
- Skewed write: AWREADY high at cycle 2, WREADY high at cycle 5 → AWVALID drops after 2, WVALID held through 5, BREADY not asserted before cycle 6.
- Backpressure: rsp_ready low 4 cycles; read RRESP=10 → rsp_valid/rdata/resp stable 4 cycles; next cmd accepted only after rsp_ready.
- Timeout: TIMEOUT=8, ARREADY stuck low → timeout_err=1 after 8 cycles, ARVALID still high; ARREADY later → read completes normally, flag stays set.
- Reset mid-write during WRESP → next cycle all VALID/READY=0, cmd_ready=1, no rsp_valid.
